// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M unit (shift-add multiply, restoring divide, one bit per cycle).
// Define MULDIV_EARLY_OUT_EN to run W ops for 32 iterations instead of 64.
module muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [12:0]     muldiv_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int HW = XLEN / 2;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WMIN = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state_q, state_d;

  function automatic logic [XLEN-1:0] sext_w(input logic [HW-1:0] v);
    return {{HW{v[HW-1]}}, v};
  endfunction

  // op order MSB..LSB: mul,mulh,mulhsu,mulhu,div,divu,rem,remu,mulw,divw,divuw,remw,remuw
  logic op_mul, op_w, op_hi, op_rem, sgn1, sgn2;
  assign op_mul = |{muldiv_op[12:9], muldiv_op[4]};
  assign op_w   = |muldiv_op[4:0];
  assign op_hi  = |muldiv_op[11:9];
  assign op_rem = |{muldiv_op[6:5], muldiv_op[1:0]};
  assign sgn1   = |{muldiv_op[12:10], muldiv_op[8], muldiv_op[6], muldiv_op[4:3], muldiv_op[1]};
  assign sgn2   = |{muldiv_op[12:11], muldiv_op[8], muldiv_op[6], muldiv_op[4:3], muldiv_op[1]};

  logic [XLEN-1:0] x1, x2, m1, m2, spec_res;
  logic            neg1, neg2, div_zero, ovf, special, early;

  always_comb begin
    x1 = src1;
    x2 = src2;
    if (op_w) begin
      x1 = sgn1 ? sext_w(src1[HW-1:0]) : {{HW{1'b0}}, src1[HW-1:0]};
      x2 = sgn2 ? sext_w(src2[HW-1:0]) : {{HW{1'b0}}, src2[HW-1:0]};
    end
    neg1     = sgn1 & x1[XLEN-1];
    neg2     = sgn2 & x2[XLEN-1];
    m1       = neg1 ? -x1 : x1;
    m2       = neg2 ? -x2 : x2;
    div_zero = ~op_mul & (x2 == '0);
    ovf      = ~op_mul & sgn1 & (x1 == (op_w ? WMIN : SMIN)) & (&x2);
    special  = div_zero | ovf;
    if (div_zero)
      spec_res = op_rem ? (op_w ? sext_w(src1[HW-1:0]) : src1) : '1;
    else
      spec_res = op_rem ? '0 : x1;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op_w;
`else
  assign early = 1'b0;
`endif

  // a: multiplier / dividend->quotient; b: multiplicand / divisor; acc: product / remainder
  logic [XLEN-1:0]   a_q, a_n;
  logic [2*XLEN-1:0] b_q, b_n, acc_q, acc_n;
  logic [CNT_W-1:0]  cnt_q;
  logic              mul_q, w_q, hi_q, rem_q, negp_q, negr_q;
  logic [XLEN-1:0]   result_q, res_d, fix_val, fix_res, quo, rmd;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     r_sh;
  logic [XLEN-1:0]   r_diff;
  logic              r_ge, ld_op, ld_res;

  always_comb begin
    a_n    = a_q;
    b_n    = b_q;
    acc_n  = acc_q;
    r_sh   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    r_diff = r_sh[XLEN-1:0] - b_q[XLEN-1:0];
    r_ge   = r_sh >= {1'b0, b_q[XLEN-1:0]};
    if (mul_q) begin
      acc_n = a_q[0] ? acc_q + b_q : acc_q;
      b_n   = b_q << 1;
      a_n   = a_q >> 1;
    end else begin
      acc_n = {{XLEN{1'b0}}, (r_ge ? r_diff : r_sh[XLEN-1:0])};
      a_n   = {a_q[XLEN-2:0], r_ge};
    end
  end

  always_comb begin
    prod    = negp_q ? -acc_q : acc_q;
    quo     = negp_q ? -a_q : a_q;
    rmd     = negr_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    fix_val = mul_q ? (hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]) : (rem_q ? rmd : quo);
    fix_res = w_q ? sext_w(fix_val[HW-1:0]) : fix_val;
  end

  always_comb begin
    state_d = state_q;
    ld_op   = 1'b0;
    ld_res  = 1'b0;
    res_d   = fix_res;
    case (state_q)
      IDLE: if (start && |muldiv_op) begin
        if (special) begin
          state_d = DONE;
          ld_res  = 1'b1;
          res_d   = spec_res;
        end else begin
          state_d = ITER;
          ld_op   = 1'b1;
        end
      end
      // flush wins over the last iteration
      ITER: if (flush) state_d = IDLE;
            else if (cnt_q == '0) state_d = FIX;
      FIX:  if (flush) state_d = IDLE;
            else begin
              state_d = DONE;
              ld_res  = 1'b1;
            end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      mul_q  <= 1'b0;
      w_q    <= 1'b0;
      hi_q   <= 1'b0;
      rem_q  <= 1'b0;
      negp_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (ld_op) begin
      // early-out W divide: park the 32-bit dividend at the top so its bits shift out first
      a_q    <= (early & ~op_mul) ? (m1 << HW) : m1;
      b_q    <= {{XLEN{1'b0}}, m2};
      acc_q  <= '0;
      cnt_q  <= early ? CNT_W'(HW - 1) : CNT_W'(XLEN - 1);
      mul_q  <= op_mul;
      w_q    <= op_w;
      hi_q   <= op_hi;
      rem_q  <= op_rem;
      negp_q <= neg1 ^ neg2;
      negr_q <= neg1;
    end else if (state_q == ITER) begin
      a_q   <= a_n;
      b_q   <= b_n;
      acc_q <= acc_n;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        result_q <= '0;
    else if (ld_res) result_q <= res_d;
  end

  assign busy   = (state_q == ITER) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed cases plus random ops against an arithmetic reference model.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [12:0] muldiv_op;
  logic [63:0] src1, src2;
  logic        busy, done;
  logic [63:0] result;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] last_res;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .muldiv_op(muldiv_op),
    .src1(src1), .src2(src2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // idx 0..12 = mul,mulh,mulhsu,mulhu,div,divu,rem,remu,mulw,divw,divuw,remw,remuw
  function automatic logic [12:0] op_of(input int idx);
    logic [12:0] v;
    v = 13'd1;
    return v << (12 - idx);
  endfunction

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_model(input int idx, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    logic signed [63:0]  a64, b64;
    logic signed [31:0]  a32, b32;
    logic [31:0]         w;
    sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
    ua = {64'd0, a};       ub = {64'd0, b};
    a64 = a; b64 = b; a32 = a[31:0]; b32 = b[31:0];
    case (idx)
      0: begin p = sa * sb; return p[63:0]; end
      1: begin p = sa * sb; return p[127:64]; end
      2: begin p = sa * ub; return p[127:64]; end
      3: begin p = ua * ub; return p[127:64]; end
      4: begin
        if (b == 0) return ONES;
        if (a == MIN64 && b == ONES) return a;
        return a64 / b64;
      end
      5: return (b == 0) ? ONES : a / b;
      6: begin
        if (b == 0) return a;
        if (a == MIN64 && b == ONES) return 64'd0;
        return a64 % b64;
      end
      7: return (b == 0) ? a : a % b;
      8: begin w = a[31:0] * b[31:0]; return sx(w); end
      9: begin
        if (b32 == 0) return ONES;
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return sx(a[31:0]);
        w = a32 / b32; return sx(w);
      end
      10: begin
        if (b[31:0] == 0) return ONES;
        w = a[31:0] / b[31:0]; return sx(w);
      end
      11: begin
        if (b32 == 0) return sx(a[31:0]);
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return 64'd0;
        w = a32 % b32; return sx(w);
      end
      default: begin
        if (b[31:0] == 0) return sx(a[31:0]);
        w = a[31:0] % b[31:0]; return sx(w);
      end
    endcase
  endfunction

  function automatic int exp_lat(input int idx, input logic [63:0] a, input logic [63:0] b);
    bit is_w, is_div, sdiv, zero, ov;
    is_w   = idx >= 8;
    is_div = !(idx <= 3 || idx == 8);
    sdiv   = (idx == 4) || (idx == 6) || (idx == 9) || (idx == 11);
    zero   = is_w ? (b[31:0] == 0) : (b == 0);
    ov     = sdiv && (is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == MIN64 && b == ONES));
    if (is_div && (zero || ov)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (is_w) return 34;
`endif
    return 66;
  endfunction

  task automatic run_op(input int idx, input logic [63:0] a, input logic [63:0] b, input string tag);
    int lat, cyc, done_cyc;
    logic busy_bad;
    logic [63:0] exp;
    exp = ref_model(idx, a, b);
    lat = exp_lat(idx, a, b);
    @(negedge clk);
    start = 1'b1; muldiv_op = op_of(idx); src1 = a; src2 = b;
    cyc = 0; done_cyc = -1; busy_bad = 1'b0;
    while (done_cyc < 0 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      // scramble inputs after accept: the unit must have latched everything it needs
      start = 1'b0; muldiv_op = '0; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
      if (busy !== (cyc < lat)) busy_bad = 1'b1;
      if (done === 1'b1) done_cyc = cyc;
    end
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(lat));
    check({tag, " busy"}, {63'd0, busy_bad}, 64'd0);
    check({tag, " result"}, result, exp);
    @(posedge clk); #1;
    check({tag, " done_fall"}, {63'd0, done}, 64'd0);
    check({tag, " hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    logic seen;
    logic [63:0] ra, rb;
    rst = 1'b0; start = 1'b0; flush = 1'b0; muldiv_op = '0; src1 = '0; src2 = '0;
    last_res = '0;
    #12;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", result, 64'd0);
    @(negedge clk); rst = 1'b1;

    run_op(0, 64'd7, -64'd3, "mul 7*-3");
    check("mul 7*-3 literal", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3, ONES, ONES, "mulhu max");
    run_op(1, ONES, ONES, "mulh -1*-1");
    run_op(4, -64'd7, 64'd2, "div -7/2");
    run_op(6, -64'd7, 64'd2, "rem -7%2");
    run_op(5, 64'd5, 64'd0, "divu by0");
    run_op(11, 64'h1_8000_0000, 64'd0, "remw by0");
    run_op(4, MIN64, ONES, "div ovf");
    run_op(6, MIN64, ONES, "rem ovf");
    run_op(2, -64'd5, ONES, "mulhsu");

    // flush mid-iteration: no done, result untouched
    @(negedge clk);
    start = 1'b1; muldiv_op = op_of(9); src1 = 64'd100; src2 = 64'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {63'd0, busy}, 64'd0);
    check("flush done", {63'd0, done}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("flush no_done", {63'd0, seen}, 64'd0);
    check("flush result", result, last_res);
    run_op(9, 64'd100, 64'd7, "divw reissue");
    check("divw literal", last_res, 64'd14);

    for (int i = 0; i < 26; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: ;
        1: begin ra = 64'($signed($urandom_range(0, 2000)) - 1000); rb = 64'($signed($urandom_range(0, 40)) - 20); end
        2: rb = {$urandom, 32'd0};
        3: begin ra = (i % 13 >= 8) ? {$urandom, 32'h8000_0000} : MIN64; rb = ONES; end
        default: rb = {32'd0, 32'($urandom_range(1, 255))};
      endcase
      run_op(i % 13, ra, rb, $sformatf("rand%0d op%0d", i, i % 13));
    end

    // asynchronous reset mid-iteration
    @(negedge clk);
    start = 1'b1; muldiv_op = op_of(0); src1 = 64'd3; src2 = 64'd4;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre-rst busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst result", result, 64'd0);
    @(negedge clk); rst = 1'b1;
    last_res = '0;

    run_op(8, 64'h10000, 64'h10000, "mulw 2^32");
    run_op(12, 64'hFFFF_FFFF_0000_0009, 64'h2, "remuw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
